// File: rtl/snn_input_packet_buffer_pkg.sv
// snn_input_packet_buffer_pkg: tick state encoding and default packet/storage sizes
package snn_input_packet_buffer_pkg;
    localparam int DSIZE_DEF = 30;
    localparam int DEPTH_DEF = 16;
    typedef enum logic [1:0] {IDLE, DRAIN, TICK, HOLDOFF} state_e;
endpackage

// File: rtl/snn_sync_fifo_fwft.sv
// snn_sync_fifo_fwft: first-word-fall-through packet store with registered full flag
module snn_sync_fifo_fwft
    import snn_input_packet_buffer_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [DSIZE-1:0] wdata,
    output logic [DSIZE-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    count_next,
    output logic             full
);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    logic [DSIZE-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic full_q, wr_acc, rd_acc;
    always_comb begin
        wr_acc = wr_en && (count_q != FULL_CNT);
        rd_acc = rd_en && (count_q != '0);
        wptr_d = wptr_q + AW'(wr_acc);
        rptr_d = rptr_q + AW'(rd_acc);
        count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
    end
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wptr_q] <= wdata;
    end
    always_ff @(posedge clk) begin
        wptr_q <= reset ? '0 : wptr_d;
        rptr_q <= reset ? '0 : rptr_d;
        count_q <= reset ? '0 : count_d;
        full_q <= reset ? 1'b0 : (count_d == FULL_CNT);
    end
    assign rdata = mem_q[rptr_q];
    assign count = count_q;
    assign count_next = count_d;
    assign full = full_q;
endmodule

// File: rtl/snn_input_packet_buffer.sv
// snn_input_packet_buffer: host packet buffer with timestep tick sequencing; SNN_IN_BUF_STATS_EN adds counters
module snn_input_packet_buffer
    import snn_input_packet_buffer_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int TICK_GAP = 8,
    localparam int CW = $clog2(DEPTH) + 1,
    localparam int GW = $clog2(TICK_GAP + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pkt_winc,
    input  logic [DSIZE-1:0] pkt_wdata,
    output logic             pkt_wfull,
    input  logic             tick_req,
    input  logic             ren_to_input_buffer,
    output logic [DSIZE-1:0] packet_in,
    output logic             input_buffer_empty,
    output logic             tick,
    output logic             busy,
    output logic             overflow_err,
    output logic             underflow_err
`ifdef SNN_IN_BUF_STATS_EN
    ,
    output logic [15:0]      pkt_accepted_cnt,
    output logic [15:0]      pkt_dropped_cnt,
    output logic [15:0]      tick_cnt
`endif
);
    localparam logic [GW-1:0] GAP_LAST = GW'(TICK_GAP - 1);
    state_e state_q, state_d;
    logic [CW-1:0] remain_q, remain_d, count, count_next;
    logic [GW-1:0] gap_q, gap_d;
    logic pending_q, pending_d, ovf_q, ovf_d, unf_q, unf_d, pop, withhold;

    snn_sync_fifo_fwft #(.DSIZE(DSIZE), .DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (pkt_winc),
        .rd_en      (pop),
        .wdata      (pkt_wdata),
        .rdata      (packet_in),
        .count      (count),
        .count_next (count_next),
        .full       (pkt_wfull)
    );

    always_comb begin
        withhold = (state_q == TICK) || (state_q == HOLDOFF) || (state_q == DRAIN && remain_q == '0);
        input_buffer_empty = (count == '0) || withhold;
        pop = ren_to_input_buffer && !input_buffer_empty;
        ovf_d = ovf_q || (pkt_winc && pkt_wfull);
        unf_d = unf_q || (ren_to_input_buffer && input_buffer_empty);
        state_d = state_q;
        remain_d = remain_q;
        gap_d = gap_q;
        pending_d = pending_q || (tick_req && state_q != IDLE);
        case (state_q)
            IDLE: begin
                state_d = tick_req ? DRAIN : IDLE;
                remain_d = tick_req ? count_next : remain_q;
            end
            DRAIN: begin
                state_d = (remain_q == '0) ? TICK : DRAIN;
                remain_d = remain_q - CW'(pop);
            end
            TICK: begin
                state_d = HOLDOFF;
                gap_d = '0;
            end
            default: begin
                if (gap_q == GAP_LAST) begin
                    state_d = pending_d ? DRAIN : IDLE;
                    remain_d = count_next;
                    pending_d = 1'b0;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            remain_q <= '0;
            gap_q <= '0;
            pending_q <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            remain_q <= remain_d;
            gap_q <= gap_d;
            pending_q <= pending_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign tick = (state_q == TICK);
    assign busy = (state_q != IDLE);
    assign overflow_err = ovf_q;
    assign underflow_err = unf_q;

`ifdef SNN_IN_BUF_STATS_EN
    logic [15:0] acc_q, acc_d, drop_q, drop_d, tcnt_q, tcnt_d;
    always_comb begin
        acc_d = (pkt_winc && !pkt_wfull && acc_q != 16'hFFFF) ? acc_q + 16'd1 : acc_q;
        drop_d = (pkt_winc && pkt_wfull && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
        tcnt_d = tcnt_q + 16'(tick);
    end
    always_ff @(posedge clk) begin
        acc_q <= reset ? '0 : acc_d;
        drop_q <= reset ? '0 : drop_d;
        tcnt_q <= reset ? '0 : tcnt_d;
    end
    assign pkt_accepted_cnt = acc_q;
    assign pkt_dropped_cnt = drop_q;
    assign tick_cnt = tcnt_q;
`endif
endmodule
